// File: rtl/uart_tx_sched.sv
// Two-requester round-robin byte scheduler driving an 8N1 UART transmit line.
// Define UART_TX_SCHED_PARITY_EN to insert a parity bit (ODD_PARITY selects its sense).
module uart_tx_sched #(
    parameter int CLKS_PER_BIT = 868
`ifdef UART_TX_SCHED_PARITY_EN
    , parameter bit ODD_PARITY = 1'b0
`endif
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       tx_out,
    output logic       busy,
    output logic       grant_id,
    output logic       tx_done
);

`ifdef UART_TX_SCHED_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    localparam logic [15:0] LAST     = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] PRE_LAST = 16'(CLKS_PER_BIT - 2);

    state_t      state;
    logic [15:0] cnt;
    logic [2:0]  idx;
    logic [7:0]  data_q;
    logic        favour1;
    logic        win1;
    logic        accept;
    logic        bit_end;
    logic [7:0]  win_data;

    // Contention goes to whichever requester was not granted last.
    always_comb begin
        win1   = 1'b0;
        accept = 1'b0;
        if (req0_valid && req1_valid)
            win1 = favour1;
        else
            win1 = req1_valid;
        accept = (state == IDLE) && !rst && (req0_valid || req1_valid);
    end

    assign req0_ready = accept && !win1;
    assign req1_ready = accept && win1;
    assign win_data   = win1 ? req1_data : req0_data;
    assign bit_end    = (cnt == LAST);

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state    <= IDLE;
            tx_out   <= 1'b1;
            busy     <= 1'b0;
            grant_id <= 1'b0;
            tx_done  <= 1'b0;
            cnt      <= '0;
            idx      <= '0;
            data_q   <= '0;
            favour1  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tx_out  <= 1'b1;
                    tx_done <= 1'b0;
                    cnt     <= '0;
                    idx     <= '0;
                    if (accept) begin
                        state    <= START;
                        data_q   <= win_data;
                        grant_id <= win1;
                        favour1  <= !win1;
                        busy     <= 1'b1;
                        tx_out   <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cnt    <= '0;
                        idx    <= '0;
                        state  <= DATA;
                        tx_out <= data_q[0];
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        idx <= idx + 3'd1;
                        if (idx == 3'd7) begin
`ifdef UART_TX_SCHED_PARITY_EN
                            state  <= PARITY;
                            tx_out <= (^data_q) ^ ODD_PARITY;
`else
                            state  <= STOP;
                            tx_out <= 1'b1;
`endif
                        end else begin
                            tx_out <= data_q[idx + 3'd1];
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
`ifdef UART_TX_SCHED_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        cnt    <= '0;
                        state  <= STOP;
                        tx_out <= 1'b1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
`endif
                STOP: begin
                    // tx_done is registered, so raise it one cycle ahead of the final stop cycle.
                    if (bit_end) begin
                        cnt     <= '0;
                        state   <= IDLE;
                        busy    <= 1'b0;
                        tx_done <= 1'b0;
                        tx_out  <= 1'b1;
                    end else begin
                        cnt     <= cnt + 16'd1;
                        tx_done <= (cnt == PRE_LAST);
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    tx_out <= 1'b1;
                end
            endcase
        end
    end

endmodule
